spm_dma: RTL and testbench
==========================

SPM_DMA -- requirements
Module: spm_dma

Interface
REQ-001 SHALL have parameter ADDR_W, default 12, meaning the SPM word-address width (must equal the `SpmAddrBus` width).
REQ-002 SHALL have parameter DATA_W, default 32, meaning the SPM word width (`WordDataBus`).
REQ-003 Ports, clock and reset first:
- clk  in  1  single system clock; one clock; all state on rising edge.
- reset_  in  1  reset, asynchronous and active-low.
- start  in  1  one-cycle command strobe; honored only when idle.
- mode  in  1  0 = copy (src to dst), 1 = fill (fill_data to dst).
- src_addr  in  ADDR_W  copy source word address.
- dst_addr  in  ADDR_W  destination word address.
- len  in  ADDR_W+1  word count, 0..2^ADDR_W.
- fill_data  in  DATA_W  fill pattern.
- abort  in  1  cancel an in-progress transfer.
- busy  out  1  transfer in progress.
- done  out  1  one-cycle completion/abort pulse.
- aborted  out  1  set with done when ended by abort; held until next start.
- remain  out  ADDR_W+1  words not yet written.
- dma_req  out  1  request for the SPM MEM-side port.
- dma_gnt  in  1  port granted this cycle.
- spm_addr  out  ADDR_W  SPM address.
- spm_as_  out  1  address strobe, active-low.
- spm_rw  out  1  1 = READ, 0 = WRITE.
- spm_wr_data  out  DATA_W  write data.
- spm_rd_data  in  DATA_W  read data, valid the cycle after a read strobe.

Function
REQ-004 SHALL implement states IDLE, RD, CAP, WR, FIN.
REQ-005 IDLE, start=1, len!=0: latch src/dst/len/mode/fill_data; go to RD (copy) or WR (fill); clear aborted.
REQ-006 IDLE, start=1, len=0: go to FIN with no SPM access.
REQ-007 start SHALL be ignored in every state other than IDLE.
REQ-008 dma_req SHALL be 1 in RD and WR, and 0 otherwise.
REQ-009 spm_as_ SHALL be 0 only when (RD or WR) and dma_gnt=1; otherwise it is 1, and spm_addr, spm_rw and spm_wr_data are don't-care.
REQ-010 RD with gnt: issue read at the current source; go to CAP. RD without gnt: hold with no side effects.
REQ-011 CAP: register spm_rd_data into the word buffer; go to WR; no SPM access.
REQ-012 WR with gnt: write the buffer (copy) or fill_data (fill) to the current destination; increment dst; decrement remain. In copy mode also increment src.
REQ-013 WR, next state: if remain becomes 0, go to FIN; otherwise go to RD (copy) or stay in WR (fill).
REQ-014 WR without gnt: hold with no side effects.
REQ-015 Addresses SHALL wrap modulo 2^ADDR_W (address 4095+1 gives 0).
REQ-016 Throughput SHALL be 3 cycles/word for copy and 1 cycle/word for fill, with continuous gnt.
REQ-017 FIN SHALL assert done for exactly one cycle, then go to IDLE.
REQ-018 busy SHALL be 1 in RD, CAP and WR.
REQ-019 abort=1 in RD, CAP or WR SHALL go to FIN without issuing an access that cycle, set aborted, and freeze remain.
REQ-020 If abort and a granted WR coincide, abort SHALL win; the write is suppressed.
REQ-021 abort in IDLE or FIN SHALL be ignored.
REQ-022 Overlapping src/dst ranges SHALL be copied in ascending address order, with no overlap correction.

Reset
REQ-023 reset_=0 SHALL immediately force IDLE with busy=0, done=0, aborted=0, remain=0, dma_req=0, spm_as_=1, spm_rw=READ, spm_addr=0, spm_wr_data=0.
REQ-024 Reset mid-transfer SHALL abandon the transfer with no done pulse.

Structure
REQ-025 State encodings, the `READ`/`WRITE` levels, and `ENABLE_`/`DISABLE_` SHALL live in the shared header spm.h; no local literals.
REQ-026 The design SHALL be a single module with no sub-module; address/count arithmetic is inline.

Verification
REQ-027 Copy, src=0x010, dst=0x100, len=4, gnt=1: words appear at 0x100..0x103; done at cycle 13 after start; busy spans 12 cycles.
REQ-028 Fill, dst=0xFFE, len=4, fill_data=0xDEADBEEF: writes to 0xFFE, 0xFFF, 0x000, 0x001; done 5 cycles after start.
REQ-029 len=0 start: no spm_as_ assertion; done one cycle after start; busy stays 0.
REQ-030 Copy len=2 with gnt low for 3 cycles during RD and WR: memory result identical; no strobe while gnt=0; done delayed 6 cycles.
REQ-031 Copy len=8 with abort asserted in the WR of the 3rd word: exactly 2 words written; remain=6; aborted=1; done pulses once.
REQ-032 reset_ low during WR of fill len=5: outputs reach reset values the same cycle; no done; a subsequent start operates normally.

Source files
------------

// File: rtl/spm_dma_pkg.sv
// spm_dma_pkg: shared FSM states and SPM bus signalling levels for the scratchpad DMA.
package spm_dma_pkg;
   typedef enum logic [2:0] {IDLE, RD, CAP, WR, FIN} state_e;
   localparam logic READ     = 1'b1;
   localparam logic WRITE    = 1'b0;
   localparam logic ENABLE_  = 1'b0;
   localparam logic DISABLE_ = 1'b1;
endpackage

// File: rtl/spm_dma.sv
// spm_dma: word-granular copy/fill engine driving the MEM-side port of the scratchpad.
module spm_dma
   import spm_dma_pkg::*;
#(
   parameter int ADDR_W = 12,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset_,
   input  logic              start,
   input  logic              mode,
   input  logic [ADDR_W-1:0] src_addr,
   input  logic [ADDR_W-1:0] dst_addr,
   input  logic [ADDR_W:0]   len,
   input  logic [DATA_W-1:0] fill_data,
   input  logic              abort,
   output logic              busy,
   output logic              done,
   output logic              aborted,
   output logic [ADDR_W:0]   remain,
   output logic              dma_req,
   input  logic              dma_gnt,
   output logic [ADDR_W-1:0] spm_addr,
   output logic              spm_as_,
   output logic              spm_rw,
   output logic [DATA_W-1:0] spm_wr_data,
   input  logic [DATA_W-1:0] spm_rd_data
);
   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   src_q, src_d, dst_q, dst_d;
   logic [ADDR_W:0]     rem_q, rem_d;
   logic                mode_q, mode_d, aborted_q, aborted_d;
   logic [DATA_W-1:0]   fill_q, fill_d, buf_q, buf_d;
   logic                act;

   assign act         = state_q == RD || state_q == WR;
   assign dma_req     = act;
   // abort wins over a grant: the strobe is suppressed in the abort cycle
   assign spm_as_     = act && dma_gnt && !abort ? ENABLE_ : DISABLE_;
   assign spm_rw      = state_q == WR ? WRITE : READ;
   assign spm_addr    = state_q == RD ? src_q : dst_q;
   assign spm_wr_data = mode_q ? fill_q : buf_q;
   assign busy        = state_q == RD || state_q == CAP || state_q == WR;
   assign done        = state_q == FIN;
   assign aborted     = aborted_q;
   assign remain      = rem_q;

   always_comb begin
      state_d   = state_q;
      src_d     = src_q;
      dst_d     = dst_q;
      rem_d     = rem_q;
      mode_d    = mode_q;
      fill_d    = fill_q;
      buf_d     = buf_q;
      aborted_d = aborted_q;
      case (state_q)
         IDLE: if (start) begin
            src_d     = src_addr;
            dst_d     = dst_addr;
            rem_d     = len;
            mode_d    = mode;
            fill_d    = fill_data;
            aborted_d = 1'b0;
            state_d   = len == '0 ? FIN : (mode ? WR : RD);
         end
         RD: state_d = abort ? FIN : (dma_gnt ? CAP : RD);
         CAP: begin
            buf_d   = spm_rd_data;
            state_d = abort ? FIN : WR;
         end
         WR: if (!abort && dma_gnt) begin
            dst_d   = dst_q + ADDR_W'(1);
            src_d   = mode_q ? src_q : src_q + ADDR_W'(1);
            rem_d   = rem_q - (ADDR_W+1)'(1);
            state_d = rem_q == (ADDR_W+1)'(1) ? FIN : (mode_q ? WR : RD);
         end else if (abort) state_d = FIN;
         FIN: state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (abort && busy) aborted_d = 1'b1;
   end

   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         state_q   <= IDLE;
         src_q     <= '0;
         dst_q     <= '0;
         rem_q     <= '0;
         mode_q    <= 1'b0;
         fill_q    <= '0;
         buf_q     <= '0;
         aborted_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         src_q     <= src_d;
         dst_q     <= dst_d;
         rem_q     <= rem_d;
         mode_q    <= mode_d;
         fill_q    <= fill_d;
         buf_q     <= buf_d;
         aborted_q <= aborted_d;
      end
   end
endmodule

// File: tb/tb_spm_dma.sv
// tb_spm_dma: scoreboard bench for spm_dma with a behavioural SPM and a reference memory.
module tb_spm_dma;
   logic        clk = 1'b0;
   logic        reset_, start, mode, abort, dma_gnt;
   logic [11:0] src_addr, dst_addr, spm_addr;
   logic [12:0] len, remain;
   logic [31:0] fill_data, spm_wr_data, spm_rd_data;
   logic        busy, done, aborted, dma_req, spm_as_, spm_rw;
   logic [31:0] mem [4096];
   logic [31:0] rm  [4096];
   logic [43:0] sb [$];
   int          errs = 0, checks = 0, done_cnt = 0, strobes = 0, bad = 0;
   int          dn, bz, d0, s0;

   spm_dma dut (
      .clk(clk), .reset_(reset_), .start(start), .mode(mode), .src_addr(src_addr),
      .dst_addr(dst_addr), .len(len), .fill_data(fill_data), .abort(abort),
      .busy(busy), .done(done), .aborted(aborted), .remain(remain), .dma_req(dma_req),
      .dma_gnt(dma_gnt), .spm_addr(spm_addr), .spm_as_(spm_as_), .spm_rw(spm_rw),
      .spm_wr_data(spm_wr_data), .spm_rd_data(spm_rd_data)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   always @(posedge clk)
      if (!spm_as_) begin
         if (spm_rw) spm_rd_data <= mem[spm_addr];
         else mem[spm_addr] <= spm_wr_data;
      end

   always @(negedge clk) begin
      if (done) done_cnt++;
      if (!spm_as_) begin
         strobes++;
         if (!dma_gnt) bad++;
         if (!spm_rw) begin
            if (sb.size() == 0) chk("sb_extra_write", 1, 0);
            else begin
               logic [43:0] e;
               e = sb.pop_front();
               chk("wr_addr", spm_addr, e[43:32]);
               chk("wr_data", spm_wr_data, e[31:0]);
            end
         end
      end
   end

   task automatic exp_copy(input logic [11:0] s, input logic [11:0] d, input int n);
      for (int i = 0; i < n; i++) begin
         logic [11:0] sa, da;
         sa = s + 12'(i);
         da = d + 12'(i);
         rm[da] = rm[sa];
         sb.push_back({da, rm[da]});
      end
   endtask

   task automatic exp_fill(input logic [11:0] d, input int n, input logic [31:0] v);
      for (int i = 0; i < n; i++) begin
         logic [11:0] da;
         da = d + 12'(i);
         rm[da] = v;
         sb.push_back({da, v});
      end
   endtask

   task automatic setup(input logic m, input logic [11:0] s, input logic [11:0] d,
                        input logic [12:0] l, input logic [31:0] f);
      mode = m; src_addr = s; dst_addr = d; len = l; fill_data = f;
      d0 = done_cnt; s0 = strobes; bad = 0;
   endtask

   // cycle n = n-th cycle after the start edge; gnt drops for 3 cycles from lo_a / lo_b
   task automatic run(input int lo_a, input int lo_b, input int ab_cyc, input int rs_cyc,
                      output int dn_o, output int bz_o);
      dn_o = 0; bz_o = 0;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int n = 1; n <= 200 && dn_o == 0; n++) begin
         dma_gnt = !((lo_a > 0 && n >= lo_a && n < lo_a + 3) || (lo_b > 0 && n >= lo_b && n < lo_b + 3));
         abort = n == ab_cyc;
         start = n == rs_cyc;
         if (start) dst_addr = 12'h555;
         if (busy) bz_o++;
         if (done) dn_o = n;
         else begin
            @(posedge clk); #1;
         end
      end
      dma_gnt = 1'b1; abort = 1'b0; start = 1'b0;
      if (dn_o == 0) chk("done_timeout", 0, 1);
      @(posedge clk); #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=hang exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 4096; i++) begin
         mem[i] = (i * 32'h0101_0101) ^ 32'hA500_0000;
         rm[i]  = mem[i];
      end
      reset_ = 1'b0; start = 1'b0; abort = 1'b0; dma_gnt = 1'b1;
      setup(1'b0, '0, '0, '0, '0);
      repeat (2) @(posedge clk);
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_as", spm_as_, 1);
      chk("rst_rw", spm_rw, 1);
      chk("rst_req", dma_req, 0);
      reset_ = 1'b1;
      @(posedge clk); #1;

      setup(1'b0, 12'h010, 12'h100, 13'd4, '0);
      exp_copy(12'h010, 12'h100, 4);
      run(0, 0, 0, 5, dn, bz);
      chk("copy_done_cyc", dn, 13);
      chk("copy_busy_cyc", bz, 12);
      chk("copy_done_pulses", done_cnt - d0, 1);
      chk("copy_sb_left", sb.size(), 0);
      chk("copy_remain", remain, 0);
      chk("copy_aborted", aborted, 0);
      chk("copy_mem", mem[12'h103], rm[12'h103]);

      setup(1'b1, '0, 12'hFFE, 13'd4, 32'hDEAD_BEEF);
      exp_fill(12'hFFE, 4, 32'hDEAD_BEEF);
      run(0, 0, 0, 0, dn, bz);
      chk("fill_done_cyc", dn, 5);
      chk("fill_busy_cyc", bz, 4);
      chk("fill_sb_left", sb.size(), 0);
      chk("fill_wrap_mem", mem[12'h001], 32'hDEAD_BEEF);

      setup(1'b0, 12'h020, 12'h030, 13'd0, '0);
      run(0, 0, 0, 0, dn, bz);
      chk("len0_done_cyc", dn, 1);
      chk("len0_busy_cyc", bz, 0);
      chk("len0_strobes", strobes - s0, 0);

      setup(1'b0, 12'h200, 12'h201, 13'd2, '0);
      exp_copy(12'h200, 12'h201, 2);
      run(1, 6, 0, 0, dn, bz);
      chk("stall_done_cyc", dn, 13);
      chk("stall_no_gnt_strobe", bad, 0);
      chk("stall_sb_left", sb.size(), 0);
      chk("overlap_mem", mem[12'h202], rm[12'h202]);

      setup(1'b0, 12'h300, 12'h400, 13'd8, '0);
      exp_copy(12'h300, 12'h400, 2);
      run(0, 0, 9, 0, dn, bz);
      chk("abort_done_cyc", dn, 10);
      chk("abort_done_pulses", done_cnt - d0, 1);
      chk("abort_remain", remain, 6);
      chk("abort_flag", aborted, 1);
      chk("abort_sb_left", sb.size(), 0);
      chk("abort_no_3rd", mem[12'h402], rm[12'h402]);
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      chk("idle_abort_busy", busy, 0);
      chk("idle_abort_done", done, 0);
      chk("idle_abort_held", aborted, 1);

      setup(1'b1, '0, 12'h800, 13'd5, 32'h1234_5678);
      exp_fill(12'h800, 1, 32'h1234_5678);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      reset_ = 1'b0;
      #1;
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_done", done, 0);
      chk("mid_rst_aborted", aborted, 0);
      chk("mid_rst_remain", remain, 0);
      chk("mid_rst_req", dma_req, 0);
      chk("mid_rst_as", spm_as_, 1);
      chk("mid_rst_rw", spm_rw, 1);
      chk("mid_rst_addr", spm_addr, 0);
      chk("mid_rst_wdata", spm_wr_data, 0);
      repeat (2) @(posedge clk);
      #1;
      reset_ = 1'b1;
      chk("mid_rst_no_done", done_cnt - d0, 0);
      chk("mid_rst_sb_left", sb.size(), 0);
      @(posedge clk); #1;

      setup(1'b0, 12'h800, 12'h900, 13'd1, '0);
      exp_copy(12'h800, 12'h900, 1);
      run(0, 0, 0, 0, dn, bz);
      chk("post_rst_done_cyc", dn, 4);
      chk("post_rst_sb_left", sb.size(), 0);
      chk("post_rst_mem", mem[12'h900], 32'h1234_5678);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
